// File: rtl/shift_register_rx.sv
// Receive end of the serial shift-register link.
// Resynchronises sdata/sclk/lclk into clk, shifts bits in LSB first on sclk
// rising edges and closes a frame on each lclk rising edge. A frame is accepted
// only when exactly WIDTH bits were shifted; otherwise a length error is pulsed.
module shift_register_rx #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdata,
  input  logic             sclk,
  input  logic             lclk,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             len_err,
  output logic [5:0]       bit_count,
  output logic             busy
);

  localparam logic [5:0] FULL_COUNT = 6'(WIDTH);
  localparam logic [5:0] SAT_COUNT  = 6'(WIDTH + 1);

  // IDLE: no bits yet; SHIFT: 1..WIDTH bits; OVER: more than WIDTH bits seen.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OVER  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sdata_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lclk_sync;
  logic                   sclk_prev;
  logic                   lclk_prev;
  logic                   sdata_s;
  logic                   sclk_rise;
  logic                   lclk_rise;

  state_t                 state;
  state_t                 state_next;
  logic [WIDTH-1:0]       shreg;
  logic [WIDTH-1:0]       shreg_next;
  logic [WIDTH-1:0]       shreg_shifted;
  logic [5:0]             count_next;
  logic [5:0]             count_shifted;
  logic [WIDTH-1:0]       word_next;
  logic                   valid_next;
  logic                   len_err_next;

  // Synchroniser chains for the three link inputs plus edge-detect history.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as a real shift chain does.
    if (rst) begin
      sdata_sync <= '0;
      sclk_sync  <= '0;
      lclk_sync  <= '0;
      sclk_prev  <= 1'b0;
      lclk_prev  <= 1'b0;
    end else begin
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      lclk_sync  <= {lclk_sync[SYNC_STAGES-2:0], lclk};
      sclk_prev  <= sclk_sync[SYNC_STAGES-1];
      lclk_prev  <= lclk_sync[SYNC_STAGES-1];
    end
  end

  assign sdata_s   = sdata_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign lclk_rise = lclk_sync[SYNC_STAGES-1] & ~lclk_prev;

  // Shift-then-latch: a bit arriving in the same cycle as the strobe counts.
  assign shreg_shifted = sclk_rise ? {sdata_s, shreg[WIDTH-1:1]} : shreg;
  assign count_shifted = !sclk_rise              ? bit_count :
                         (bit_count == SAT_COUNT) ? SAT_COUNT : bit_count + 6'd1;

  // Next-state, datapath and output pulse decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_next   = state;
    shreg_next   = shreg_shifted;
    count_next   = count_shifted;
    word_next    = word;
    valid_next   = 1'b0;
    len_err_next = 1'b0;

    case (state)
      IDLE:    if (sclk_rise) state_next = SHIFT;
      SHIFT:   if (sclk_rise && bit_count == FULL_COUNT) state_next = OVER;
      OVER:    state_next = OVER;
      default: state_next = IDLE;
    endcase

    if (lclk_rise) begin
      if (count_shifted == FULL_COUNT) begin
        word_next  = shreg_shifted;
        valid_next = 1'b1;
      end else begin
        len_err_next = 1'b1;
      end
      shreg_next = '0;
      count_next = '0;
      state_next = IDLE;
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_count <= '0;
      word      <= '0;
      valid     <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_count <= count_next;
      word      <= word_next;
      valid     <= valid_next;
      len_err   <= len_err_next;
    end
  end

  assign busy = (bit_count != 6'd0);

endmodule
